// File: rtl/crc_multi_pkg.sv
// Shared types and helpers for the multi-byte reflected CRC-32 unit.
package crc_multi_pkg;

  localparam int CRC_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } crc_state_t;

  // One entry of the byte-wise lookup table for a reflected (LSB-first)
  // polynomial: the index shifted right eight times, folding in the
  // polynomial whenever a 1 falls off the bottom.
  function automatic logic [CRC_W-1:0] crc_tbl_entry(input logic [CRC_W-1:0] poly,
                                                     input logic [7:0]       idx);
    logic [CRC_W-1:0] c;
    c = {{(CRC_W-8){1'b0}}, idx};
    for (int b = 0; b < 8; b++) begin
      c = c[0] ? ((c >> 1) ^ poly) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc_multi_if.sv
// Request/response bus of the CRC custom-instruction unit.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. The sender holds valid and its payload stable until that
// edge; ready may be high or low independently of valid. Request payload
// (req_data0, req_data1, req_nbytes, req_id) travels with req_valid;
// response payload (resp_crc, resp_id) travels with resp_valid.
interface crc_multi_if #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  import crc_multi_pkg::*;

  localparam int NB  = DATA_W / 8;
  localparam int NBW = $clog2(NB) + 1;

  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_data0;
  logic [CRC_W-1:0]  req_data1;
  logic [NBW-1:0]    req_nbytes;
  logic [ID_W-1:0]   req_id;

  logic              resp_valid;
  logic              resp_ready;
  logic [CRC_W-1:0]  resp_crc;
  logic [ID_W-1:0]   resp_id;

  // Requester side (CPU pipeline).
  modport master (
    output req_valid, req_data0, req_data1, req_nbytes, req_id, resp_ready,
    input  req_ready, resp_valid, resp_crc, resp_id
  );

  // CRC unit side.
  modport slave (
    input  req_valid, req_data0, req_data1, req_nbytes, req_id, resp_ready,
    output req_ready, resp_valid, resp_crc, resp_id
  );

endinterface

// File: rtl/crc_byte_step.sv
// One combinational byte step of a reflected CRC-32:
//   crc_out = T[(crc_in ^ byte_in) & 8'hFF] ^ (crc_in >> 8)
// The 256-entry table is constant, derived from POLY at elaboration.
module crc_byte_step
  import crc_multi_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = 32'hEDB88320
) (
  input  logic [CRC_W-1:0] crc_in,
  input  logic [7:0]       byte_in,
  output logic [CRC_W-1:0] crc_out
);

  logic [CRC_W-1:0] tbl [256];
  logic [7:0]       idx;

  for (genvar i = 0; i < 256; i++) begin : g_tbl
    assign tbl[i] = crc_tbl_entry(POLY, 8'(i));
  end

  // Table lookup on the low CRC byte mixed with the message byte.
  always_comb begin
    idx     = crc_in[7:0] ^ byte_in;
    crc_out = tbl[idx] ^ (crc_in >> 8);
  end

endmodule

// File: rtl/crc_multi.sv
// Multi-byte CRC-32 custom-instruction unit. Accepts up to DATA_W/8 message
// bytes plus a running CRC, folds LANES bytes per cycle through a chain of
// byte steps, and returns the updated CRC with the request tag.
// No init value or final XOR is applied; software owns both.
module crc_multi
  import crc_multi_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY   = 32'hEDB88320,
  parameter int               DATA_W = 32,
  parameter int               LANES  = 1,
  parameter int               ID_W   = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  crc_multi_if.slave bus,
  output crc_state_t dbg_state
);

  localparam int NB  = DATA_W / 8;
  localparam int NBW = $clog2(NB) + 1;

  crc_state_t        state_q, state_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [CRC_W-1:0]  crc_q,   crc_d;
  logic [NBW-1:0]    rem_q,   rem_d;
  logic [ID_W-1:0]   id_q,    id_d;

  logic [NBW-1:0]           req_rem;
  logic [NBW-1:0]           k;
  logic [NBW+2:0]           shamt;
  logic [CRC_W-1:0]         crc_fold;
  logic [LANES:0][CRC_W-1:0] lane_crc;

  // Lane chain: lane l folds data byte l into the output of lane l-1.
  assign lane_crc[0] = crc_q;
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    crc_byte_step #(
      .POLY(POLY)
    ) u_step (
      .crc_in (lane_crc[l]),
      .byte_in(data_q[8*l +: 8]),
      .crc_out(lane_crc[l+1])
    );
  end

  // Clamp the requested byte count to the word size.
  always_comb begin
    req_rem = bus.req_nbytes;
    if (bus.req_nbytes > NBW'(NB)) begin
      req_rem = NBW'(NB);
    end
  end

  // Bytes folded this cycle and the tap taken from the lane chain; lanes
  // beyond k are bypassed so a short tail does not over-fold.
  always_comb begin
    k = NBW'(LANES);
    if (rem_q < NBW'(LANES)) begin
      k = rem_q;
    end
    shamt    = {k, 3'b000};
    crc_fold = lane_crc[0];
    for (int l = 1; l <= LANES; l++) begin
      if (NBW'(l) == k) begin
        crc_fold = lane_crc[l];
      end
    end
  end

  // Next-state and datapath update for IDLE -> BUSY -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    crc_d   = crc_q;
    rem_d   = rem_q;
    id_d    = id_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          data_d  = bus.req_data0;
          crc_d   = bus.req_data1;
          id_d    = bus.req_id;
          rem_d   = req_rem;
          state_d = (req_rem == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        crc_d  = crc_fold;
        data_d = data_q >> shamt;
        rem_d  = rem_q - k;
        if (rem_q == k) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      crc_q   <= '0;
      rem_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      crc_q   <= crc_d;
      rem_q   <= rem_d;
      id_q    <= id_d;
    end
  end

  // Handshake flags come straight from the state; results are the
  // registered CRC and tag, stable for the whole DONE stay.
  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == DONE);
  assign bus.resp_crc   = crc_q;
  assign bus.resp_id    = id_q;
  assign dbg_state      = state_q;

endmodule
